// File: rtl/button_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_io_responder_if
//  Description : Read-side bus between the CPU memory/IO address decoder and
//                the button responder.
//                  ButtonCtrl1 - status-read chip select (ioRead-qualified)
//                  ButtonCtrl2 - event-read chip select  (ioRead-qualified)
//                  io_rdata    - 16-bit read data back to the decoder
//                The master modport is the decoder side. The slave modport is
//                the responder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_io_responder_if;
    logic        ButtonCtrl1;
    logic        ButtonCtrl2;
    logic [15:0] io_rdata;

    modport master (
        output ButtonCtrl1,
        output ButtonCtrl2,
        input  io_rdata
    );

    modport slave (
        input  ButtonCtrl1,
        input  ButtonCtrl2,
        output io_rdata
    );
endinterface
`default_nettype wire

// File: rtl/button_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : button_io_responder
//  Description : Peripheral-side responder for the two button chip selects.
//                The module synchronises and debounces the raw board
//                buttons. It keeps the stable levels and sticky press-event
//                flags with an overflow bit. It returns 16-bit read data to
//                the decoder combinationally, in the same cycle as the chip
//                select. An event read (ButtonCtrl2) clears the flags.
//
//  Ports       : clk         - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                button_raw  - raw button pins, asynchronous, active high
//                bus         - slave side of button_io_responder_if
//                              (ButtonCtrl1, ButtonCtrl2, io_rdata)
//                btn_level   - debounced button levels
//                evt_pending - OR of all pending event flags
//
//  Parameters  : NUM_BTN         - number of buttons, 1..7
//                DEBOUNCE_CYCLES - cycles a new level must persist, >= 2
//
//  Build macro : BUTTON_RELEASE_EVT_EN
//                When defined, the module also keeps sticky release flags.
//                They are returned in io_rdata[NUM_BTN+7:8] on an event read
//                and are included in evt_pending.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_io_responder #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [NUM_BTN-1:0]   button_raw,
    button_io_responder_if.slave      bus,
    output logic      [NUM_BTN-1:0]   btn_level,
    output logic                      evt_pending
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser. The second stage is the debounce input.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce. Each counter measures how long the synchronised
    // input has disagreed with the accepted level. Any agreement restarts
    // the count, so a glitch shorter than DEBOUNCE_CYCLES is never
    // accepted.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             bit_d;

        always_comb begin
            cnt_d = cnt_q;
            bit_d = level_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                bit_d = sync2_q[i];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign level_d[i] = bit_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection on the accepted level. The edge is taken from the
    // next-state value, so a flag sets on the same edge as the level.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] rise;
    logic               rd_clr;

    assign rise   = level_d & ~level_q;
    // A status read has priority, so a cycle with both selects high is a
    // status read and does not clear anything.
    assign rd_clr = bus.ButtonCtrl2 & ~bus.ButtonCtrl1;

    // ------------------------------------------------------------------
    // Sticky flags. The clear is applied first and the new edges are OR'd
    // in afterwards. A press that lands on the clearing edge therefore
    // survives: it was not part of the data that was just returned. The
    // same ordering means such a press cannot count as an overflow.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] evt_q;
    logic [NUM_BTN-1:0] evt_d;
    logic [NUM_BTN-1:0] evt_kept;
    logic               ovf_q;
    logic               ovf_d;
    logic               ovf_hit;

`ifdef BUTTON_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] rel_q;
    logic [NUM_BTN-1:0] rel_d;
    logic [NUM_BTN-1:0] rel_kept;

    assign fall = ~level_d & level_q;

    always_comb begin
        evt_kept = rd_clr ? '0 : evt_q;
        rel_kept = rd_clr ? '0 : rel_q;
        evt_d    = evt_kept | rise;
        rel_d    = rel_kept | fall;
        ovf_hit  = (|(rise & evt_kept)) | (|(fall & rel_kept));
        ovf_d    = (rd_clr ? 1'b0 : ovf_q) | ovf_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_d;
        end
    end
`else
    always_comb begin
        evt_kept = rd_clr ? '0 : evt_q;
        evt_d    = evt_kept | rise;
        ovf_hit  = |(rise & evt_kept);
        ovf_d    = (rd_clr ? 1'b0 : ovf_q) | ovf_hit;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data. This path is combinational so that the single-cycle CPU
    // sees the data in the same cycle as the chip select.
    // ------------------------------------------------------------------
    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        if (bus.ButtonCtrl1) begin
            rdata[NUM_BTN-1:0] = level_q;
        end else if (bus.ButtonCtrl2) begin
            rdata[NUM_BTN-1:0] = evt_q;
            rdata[15]          = ovf_q;
`ifdef BUTTON_RELEASE_EVT_EN
            rdata[NUM_BTN+7:8] = rel_q;
`endif
        end
    end

    assign bus.io_rdata = rdata;
    assign btn_level    = level_q;

`ifdef BUTTON_RELEASE_EVT_EN
    assign evt_pending  = (|evt_q) | (|rel_q);
`else
    assign evt_pending  = |evt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_io_responder
//  Description : Self-checking directed bench for button_io_responder.
//                It runs with NUM_BTN=5 and DEBOUNCE_CYCLES=4. Expected
//                values are hand-computed, and the release-flag variant is
//                selected with BUTTON_RELEASE_EVT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_io_responder;

    localparam int NUM_BTN = 5;
    localparam int DEB     = 4;
`ifdef BUTTON_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NUM_BTN-1:0] button_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic               evt_pending;

    button_io_responder_if bus ();

    button_io_responder #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_raw  (button_raw),
        .bus         (bus.slave),
        .btn_level   (btn_level),
        .evt_pending (evt_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        c1;
        logic        c2;
        logic [15:0] exp_rdata;   // combinational, before the edge
        logic [4:0]  exp_level;   // after the edge
        logic        exp_pend;    // after the edge
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Look at the event register without clearing it: the select is
    // dropped again before any clock edge.
    task automatic peek(input string name, input logic [15:0] exp);
        bus.ButtonCtrl2 = 1'b1;
        #1;
        chk(name, bus.io_rdata, exp);
        bus.ButtonCtrl2 = 1'b0;
        #1;
    endtask

    task automatic clear_read();
        bus.ButtonCtrl2 = 1'b1;
        tick(1);
        bus.ButtonCtrl2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Status/event read table. Button 2 is held, level=0x04 and evt=0x04.
        vt[0] = '{1'b1, 1'b0, 16'h0004, 5'h04, 1'b1};  // status read, no side effect
        vt[1] = '{1'b1, 1'b1, 16'h0004, 5'h04, 1'b1};  // both selects: status wins, no clear
        vt[2] = '{1'b0, 1'b1, 16'h0004, 5'h04, 1'b0};  // event read, clears
        vt[3] = '{1'b0, 1'b1, 16'h0000, 5'h04, 1'b0};  // second event read empty
        vt[4] = '{1'b0, 1'b0, 16'h0000, 5'h04, 1'b0};  // idle bus reads 0
        vt[5] = '{1'b1, 1'b0, 16'h0004, 5'h04, 1'b0};  // level still visible

        rst_n           = 1'b0;
        button_raw      = '0;
        bus.ButtonCtrl1 = 1'b0;
        bus.ButtonCtrl2 = 1'b0;
        tick(3);

        // ---- Reset state ----
        chk("reset_level", 16'(btn_level), 16'h0000);
        chk("reset_pend", 16'(evt_pending), 16'h0000);
        chk("reset_rdata_idle", bus.io_rdata, 16'h0000);
        peek("reset_evt_read", 16'h0000);
        tick(1);

        // ---- Reset mid-debounce ----
        rst_n      = 1'b1;
        button_raw = 5'b00001;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 16'(btn_level), 16'h0000);
        chk("midrst_pend", 16'(evt_pending), 16'h0000);
        bus.ButtonCtrl1 = 1'b1;
        #1;
        chk("midrst_rdata", bus.io_rdata, 16'h0000);
        bus.ButtonCtrl1 = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("midrst_level_5cyc", 16'(btn_level), 16'h0000);
        tick(1);
        chk("midrst_level_6cyc", 16'(btn_level), 16'h0001);
        chk("midrst_pend_set", 16'(evt_pending), 16'h0001);
        peek("midrst_evt", 16'h0001);
        clear_read();
        chk("clear_pend", 16'(evt_pending), 16'h0000);
        button_raw = '0;
        tick(8);
        chk("release_level", 16'(btn_level), 16'h0000);
        chk("release_no_evt", 16'(evt_pending), REL ? 16'h0001 : 16'h0000);
        clear_read();

        // ---- Glitch rejection ----
        button_raw = 5'b00010;
        tick(3);
        button_raw = '0;
        tick(10);
        chk("glitch_level", 16'(btn_level), 16'h0000);
        chk("glitch_pend", 16'(evt_pending), 16'h0000);
        button_raw = 5'b00010;
        tick(5);
        chk("press1_level_5cyc", 16'(btn_level), 16'h0000);
        tick(1);
        chk("press1_level_6cyc", 16'(btn_level), 16'h0002);
        peek("press1_evt", 16'h0002);
        button_raw = '0;
        tick(8);
        clear_read();

        // ---- Status vs event read (table) ----
        button_raw = 5'b00100;
        tick(6);
        chk("press2_level", 16'(btn_level), 16'h0004);
        for (int k = 0; k < 6; k++) begin
            bus.ButtonCtrl1 = vt[k].c1;
            bus.ButtonCtrl2 = vt[k].c2;
            #1;
            chk($sformatf("vec%0d_rdata", k), bus.io_rdata, vt[k].exp_rdata);
            tick(1);
            chk($sformatf("vec%0d_level", k), 16'(btn_level), 16'(vt[k].exp_level));
            chk($sformatf("vec%0d_pend", k), 16'(evt_pending), 16'(vt[k].exp_pend));
        end
        bus.ButtonCtrl1 = 1'b0;
        bus.ButtonCtrl2 = 1'b0;

        // ---- Overflow ----
        button_raw = '0;
        tick(8);
        chk("rel2_level", 16'(btn_level), 16'h0000);
        chk("rel2_pend", 16'(evt_pending), REL ? 16'h0001 : 16'h0000);
        clear_read();
        for (int k = 0; k < 2; k++) begin
            button_raw = 5'b00001;
            tick(8);
            button_raw = '0;
            tick(8);
        end
        bus.ButtonCtrl2 = 1'b1;
        #1;
        chk("ovf_read1", bus.io_rdata, REL ? 16'h8101 : 16'h8001);
        tick(1);
        chk("ovf_read2", bus.io_rdata, 16'h0000);
        tick(1);
        bus.ButtonCtrl2 = 1'b0;
        chk("ovf_pend_clr", 16'(evt_pending), 16'h0000);

        // ---- Simultaneous press and clear ----
        button_raw = 5'b00001;
        tick(8);
        peek("simul_pre_evt", 16'h0001);
        button_raw = 5'b01001;
        tick(5);
        bus.ButtonCtrl2 = 1'b1;
        #1;
        chk("simul_read", bus.io_rdata, 16'h0001);
        chk("simul_level_pre", 16'(btn_level), 16'h0001);
        tick(1);
        bus.ButtonCtrl2 = 1'b0;
        chk("simul_level_post", 16'(btn_level), 16'h0009);
        chk("simul_pend", 16'(evt_pending), 16'h0001);
        peek("simul_evt_post", 16'h0008);

        // ---- Release event (button 4) ----
        tick(1);
        button_raw = '0;
        tick(8);
        clear_read();
        chk("pre_rel_pend", 16'(evt_pending), 16'h0000);
        button_raw = 5'b10000;
        tick(8);
        button_raw = '0;
        tick(8);
        chk("btn4_pend", 16'(evt_pending), 16'h0001);
        bus.ButtonCtrl2 = 1'b1;
        #1;
        chk("btn4_read", bus.io_rdata, REL ? 16'h1010 : 16'h0010);
        tick(1);
        bus.ButtonCtrl2 = 1'b0;
        chk("btn4_pend_clr", 16'(evt_pending), 16'h0000);
        peek("btn4_evt_empty", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
